// File: rtl/genome_rle_pkg.sv
// Shared types and constants for the name run-length pipeline.
// Record layout {name, count}, word slicing and packer FSM encoding.
package genome_rle_pkg;

  localparam int STR_W = 128;
  localparam int CNT_W = 32;
  localparam int REC_W = STR_W + CNT_W;
  localparam int OUT_W = 32;
  localparam int WORDS_PER_REC = REC_W / OUT_W;
  localparam int IDX_W = 3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef logic [REC_W-1:0] rec_t;

  // Word i of a record, most significant word first.
  function automatic logic [OUT_W-1:0] rec_word(
    input rec_t             r,
    input logic [IDX_W-1:0] i
  );
    logic [OUT_W-1:0] w;
    case (i)
      3'd0:    w = r[OUT_W*4 +: OUT_W];
      3'd1:    w = r[OUT_W*3 +: OUT_W];
      3'd2:    w = r[OUT_W*2 +: OUT_W];
      3'd3:    w = r[OUT_W*1 +: OUT_W];
      default: w = r[OUT_W*0 +: OUT_W];
    endcase
    return w;
  endfunction

endpackage

// File: rtl/rle_record_fifo.sv
// Synchronous record FIFO, DEPTH entries (power of 2, >= 2).
// Ports: clk, reset, push/wdata, pop/rdata (registered on pop), full, empty.
module rle_record_fifo
  import genome_rle_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  rec_t wdata,
  input  logic pop,
  output rec_t rdata,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  rec_t        mem [DEPTH];
  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit separates full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
    if (do_pop)  rdata <= mem[rptr[AW-1:0]];
  end

endmodule

// File: rtl/rle_record_packer.sv
// Buffers {name,count} records and streams each as five 32-bit words.
// Ports: in_write/in_record/in_full, out_valid/ready/data/last,
// overflow (sticky), rec_count (records fully emitted).
module rle_record_packer
  import genome_rle_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit DROP_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_write,
  input  logic [REC_W-1:0] in_record,
  output logic             in_full,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             overflow,
  output logic [31:0]      rec_count
);

  logic [0:0]       state;
  logic [IDX_W-1:0] idx;
  rec_t             hold;
  logic             empty;
  logic             zero_cnt;
  logic             wr_ok;
  logic             accept;
  logic             lastw;
  logic             done;
  logic             pop;

  assign zero_cnt = (in_record[CNT_W-1:0] == '0);
  assign wr_ok    = in_write && !in_full &&
                    !(DROP_ZERO && zero_cnt);

  assign out_valid = (state == ST_SEND);
  assign lastw     = (idx == IDX_W'(WORDS_PER_REC-1));
  assign accept    = out_valid && out_ready;
  assign done      = accept && lastw;

  // Refill the holding register when idle or as the
  // last word leaves, so records run back to back.
  assign pop = !empty && ((state == ST_IDLE) || done);

  assign out_data = out_valid ? rec_word(hold, idx) : '0;
  assign out_last = out_valid && lastw;

  rle_record_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_ok),
    .wdata (in_record),
    .pop   (pop),
    .rdata (hold),
    .full  (in_full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      idx       <= '0;
      overflow  <= 1'b0;
      rec_count <= '0;
    end else begin
      if (in_write && in_full) overflow <= 1'b1;
      if (done) rec_count <= rec_count + 32'd1;
      if (pop) begin
        state <= ST_SEND;
        idx   <= '0;
      end else if (done) begin
        state <= ST_IDLE;
        idx   <= '0;
      end else if (accept) begin
        idx <= idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_rle_record_packer.sv
// Randomised and directed bench for rle_record_packer against a
// queue-level model of the record stream.
module tb_rle_record_packer;
  import genome_rle_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_write = 1'b0;
  rec_t        in_record = '0;
  logic        in_full;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_last;
  logic        overflow;
  logic [31:0] rec_count;

  rle_record_packer #(
    .DEPTH     (DEPTH),
    .DROP_ZERO (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_write  (in_write),
    .in_record (in_record),
    .in_full   (in_full),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow),
    .rec_count (rec_count)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: mq = records waiting in the FIFO,
  // mcur/mbusy/midx = record currently being sent.
  rec_t        mq[$];
  rec_t        mcur;
  bit          mbusy = 0;
  int          midx = 0;
  bit          movf = 0;
  logic [31:0] mcnt = 0;
  bit          started = 0;
  bit          m_full, m_acc, m_last, m_pop;

  function automatic logic [31:0] wordof(rec_t r, int i);
    return r[(4-i)*32 +: 32];
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (reset) begin
      mq.delete();
      mbusy = 0;
      midx  = 0;
      movf  = 0;
      mcnt  = 0;
    end else begin
      m_full = (mq.size() == DEPTH);
      m_acc  = mbusy && out_ready;
      m_last = m_acc && (midx == 4);
      m_pop  = (mq.size() != 0) && (!mbusy || m_last);
      if (m_last) begin
        mcnt++;
        mbusy = 0;
      end else if (m_acc) begin
        midx++;
      end
      if (m_pop) begin
        mcur  = mq.pop_front();
        mbusy = 1;
        midx  = 0;
      end
      if (in_write) begin
        if (m_full) movf = 1;
        else if (in_record[31:0] != 0)
          mq.push_back(in_record);
      end
    end
  end

  logic [32:0] got[$];

  always @(negedge clk) begin
    if (started) begin
      chk("valid", 32'(out_valid), 32'(mbusy));
      if (mbusy) begin
        chk("data", out_data, wordof(mcur, midx));
        chk("last", 32'(out_last), 32'(midx == 4));
      end
      chk("full", 32'(in_full), 32'(mq.size() == DEPTH));
      chk("ovf", 32'(overflow), 32'(movf));
      chk("rcnt", rec_count, mcnt);
      if (out_valid && out_ready)
        got.push_back({out_last, out_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_write = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wr(input rec_t r);
    in_write = 1'b1;
    in_record = r;
    tick();
    in_write = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (got.size() >= n) return;
      tick();
    end
    chk("timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic check_rec(input string nm,
                           input int base,
                           input rec_t r);
    for (int i = 0; i < 5; i++) begin
      if (base + i >= got.size()) begin
        chk({nm, "_missing"}, 32'(got.size()),
            32'(base + i + 1));
        return;
      end
      chk({nm, "_w"}, got[base+i][31:0], wordof(r, i));
      chk({nm, "_l"}, 32'(got[base+i][32]), 32'(i == 4));
    end
  endtask

  localparam logic [127:0] NM =
    128'h00112233_44556677_8899AABB_CCDDEEFF;

  rec_t r0;
  int   base;

  initial begin
    // 1: reset values
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(in_full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_rcnt", rec_count, 32'd0);
    chk("rst_data", out_data, 32'd0);

    // 2: single record, full throughput
    out_ready = 1'b1;
    r0 = {NM, 32'd7};
    base = got.size();
    wr(r0);
    wait_got(base + 5, 40);
    chk("t2_w0", got[base][31:0], 32'h00112233);
    chk("t2_w4", got[base+4][31:0], 32'h00000007);
    check_rec("t2", base, r0);
    chk("t2_rcnt", rec_count, 32'd1);

    // 3: toggling ready
    do_reset();
    base = got.size();
    out_ready = 1'b1;
    wr(r0);
    for (int i = 0; i < 60; i++) begin
      if (got.size() >= base + 5) break;
      out_ready = ~out_ready;
      tick();
    end
    chk("t3_n", 32'(got.size() - base), 32'd5);
    check_rec("t3", base, r0);
    out_ready = 1'b1;
    tick();
    chk("t3_rcnt", rec_count, 32'd1);

    // 4: fill, overflow, drain
    do_reset();
    for (int k = 1; k <= 5; k++) wr({NM, 32'(k)});
    chk("t4_full", 32'(in_full), 32'd1);
    wr({NM, 32'd6});
    chk("t4_ovf", 32'(overflow), 32'd1);
    base = got.size();
    out_ready = 1'b1;
    wait_got(base + 25, 80);
    for (int k = 1; k <= 5; k++)
      check_rec("t4", base + 5*(k-1), {NM, 32'(k)});
    tick();
    chk("t4_n", 32'(got.size() - base), 32'd25);
    chk("t4_rcnt", rec_count, 32'd5);
    chk("t4_ovf2", 32'(overflow), 32'd1);

    // 5: zero-count drop
    do_reset();
    out_ready = 1'b1;
    base = got.size();
    wr({NM, 32'd0});
    wr({NM, 32'd3});
    wait_got(base + 5, 40);
    repeat (6) tick();
    chk("t5_n", 32'(got.size() - base), 32'd5);
    check_rec("t5", base, {NM, 32'd3});
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_rcnt", rec_count, 32'd1);

    // 6: reset mid-record
    do_reset();
    out_ready = 1'b1;
    base = got.size();
    wr({NM, 32'd11});
    wr({NM, 32'd12});
    wr({NM, 32'd13});
    wait_got(base + 2, 20);
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    reset = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_n", 32'(got.size() - base), 32'd2);
    out_ready = 1'b1;
    repeat (5) tick();
    chk("t6_idle", 32'(got.size() - base), 32'd2);
    base = got.size();
    wr({NM, 32'd14});
    wait_got(base + 5, 40);
    check_rec("t6", base, {NM, 32'd14});
    tick();
    chk("t6_rcnt", rec_count, 32'd1);

    // Random traffic against the model
    do_reset();
    for (int blk = 0; blk < 12; blk++) begin
      int rp;
      int wp;
      rp = $urandom_range(1, 4);
      wp = $urandom_range(1, 6);
      for (int c = 0; c < 250; c++) begin
        in_write = ($urandom_range(0, wp) == 0);
        in_record = {$urandom(), $urandom(), $urandom(),
                     $urandom(),
                     ($urandom_range(0, 4) == 0) ?
                       32'd0 : $urandom()};
        out_ready = ($urandom_range(0, rp) != 0);
        tick();
      end
      if (blk == 5) do_reset();
    end
    in_write = 1'b0;
    out_ready = 1'b1;
    repeat (60) tick();
    chk("drain_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
